main_mem_arbiter: RTL and testbench
===================================

Name: main_mem_arbiter

Overview:
- Shares the single main-memory port between two requesters.
- Port 0 is instruction fetch and is read-only. Port 1 is the memory execution element and issues both loads and stores.
- Downstream side has the same valid/ready read and write channels the exec element drives today.
- Serves one transaction at a time. Round-robin between ports; responses are registered back to the winner.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
p0_rd_addr  in  ADDR_W  fetch read address
p0_rd_valid  in  1  fetch read request
p0_rd_data  out  DATA_W  fetch read data
p0_rd_ready  out  1  fetch read done pulse
p1_rd_addr  in  ADDR_W  exec read address
p1_rd_valid  in  1  exec read request
p1_rd_data  out  DATA_W  exec read data
p1_rd_ready  out  1  exec read done pulse
p1_wr_addr  in  ADDR_W  exec write address
p1_wr_data  in  DATA_W  exec write data
p1_wr_valid  in  1  exec write request
p1_wr_ready  out  1  exec write done pulse
mem_rd_addr  out  ADDR_W  memory read address
mem_rd_valid  out  1  memory read request
mem_rd_data  in  DATA_W  memory read data
mem_rd_ready  in  1  memory read done
mem_wr_addr  out  ADDR_W  memory write address
mem_wr_data  out  DATA_W  memory write data
mem_wr_valid  out  1  memory write request
mem_wr_ready  in  1  memory write done

Behaviour:
- Reset (reset=0, async): state=IDLE, all valid/ready outputs 0, addr/data outputs 0, last_grant=1 (port 0 wins first), mask=none.
- Handshake contract:
  - Requester holds valid, addr and data stable until it sees its ready.
  - Ready is a one-cycle pulse.
  - Requester drops valid on the edge after it samples ready.
- State IDLE:
  - Candidates are p0 read, p1 write and p1 read; the masked port is excluded.
  - If p1 write and p1 read are both valid, write wins.
  - If both ports request, grant the port != last_grant; otherwise grant the sole requester.
  - On grant: latch port/op, set last_grant, drive mem_*_addr/data, assert mem_rd_valid or mem_wr_valid next cycle, go ISSUE.
  - Mask clears after one IDLE cycle.
- State ISSUE:
  - Hold mem valid/addr/data.
  - mem_*_ready is ignored unless it matches the active op.
  - On matching ready: deassert mem valid, capture mem_rd_data into the granted pN_rd_data (reads only), go RESP.
  - No timeout; stalls indefinitely.
- State RESP:
  - Assert exactly one of p0_rd_ready/p1_rd_ready/p1_wr_ready for one cycle.
  - Go IDLE with mask = granted port.
- Latency:
  - Request sampled at edge E → mem valid high after E.
  - mem ready sampled at edge E+k → requester ready high after E+k+1.
  - Minimum round trip: 3 cycles from request to ready.
- pN_rd_data holds its last value until the next read for that port completes.
- Mem ready arriving in IDLE/RESP, or on the inactive channel, is ignored.
- Never more than one mem valid high; never more than one pN ready high.
- Reset mid-transaction aborts immediately; a downstream write in flight may or may not have landed.

Test Plan:
- Single fetch: p0 read 0x100; mem returns 0xDEADBEEF after 2-cycle stall → mem_rd_valid/addr=0x100 one cycle after request; p0_rd_data=0xDEADBEEF with a p0_rd_ready pulse; no p1 activity.
- Exec store: p1 write addr 0x40, data 0x12345678, mem_wr_ready immediate → mem_wr_addr/data match; one p1_wr_ready pulse; mem_rd_valid stays 0.
- Contention from reset: p0 read 0x0 and p1 read 0x4 in the same cycle → p0 served first, then p1; p1 issued in the IDLE cycle immediately after p0's RESP.
- Fairness: both ports re-request continuously for 6 transactions → grants alternate 0,1,0,1,0,1; no port gets two consecutive grants while the other waits.
- Spurious and stray readies: mem_wr_ready pulsed during a read, and mem_rd_ready pulsed in IDLE → no state change, no pN ready.
- Reset mid-op: reset=0 while in ISSUE with mem_rd_valid=1 → all valids/readies 0 at once; after release, a p1 request is served normally and p0 holds the first grant.

Source files
------------

// File: rtl/main_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : main_mem_arbiter
// Purpose  : Round-robin arbiter sharing one main-memory port between the
//            instruction fetch port (p0, read-only) and the exec port (p1).
// Revision : 1.0 - initial release
// ============================================================================
module main_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] p0_rd_addr,
    input  logic              p0_rd_valid,
    output logic [DATA_W-1:0] p0_rd_data,
    output logic              p0_rd_ready,
    input  logic [ADDR_W-1:0] p1_rd_addr,
    input  logic              p1_rd_valid,
    output logic [DATA_W-1:0] p1_rd_data,
    output logic              p1_rd_ready,
    input  logic [ADDR_W-1:0] p1_wr_addr,
    input  logic [DATA_W-1:0] p1_wr_data,
    input  logic              p1_wr_valid,
    output logic              p1_wr_ready,
    output logic [ADDR_W-1:0] mem_rd_addr,
    output logic              mem_rd_valid,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic              mem_rd_ready,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic              mem_wr_valid,
    input  logic              mem_wr_ready
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t            r_state,        w_state_nxt;
    logic              r_last_grant,   w_last_grant_nxt;
    logic              r_mask_vld,     w_mask_vld_nxt;
    logic              r_mask_port,    w_mask_port_nxt;
    logic              r_gnt_port,     w_gnt_port_nxt;
    logic              r_gnt_wr,       w_gnt_wr_nxt;
    logic [ADDR_W-1:0] r_mem_rd_addr,  w_mem_rd_addr_nxt;
    logic [ADDR_W-1:0] r_mem_wr_addr,  w_mem_wr_addr_nxt;
    logic [DATA_W-1:0] r_mem_wr_data,  w_mem_wr_data_nxt;
    logic              r_mem_rd_valid, w_mem_rd_valid_nxt;
    logic              r_mem_wr_valid, w_mem_wr_valid_nxt;
    logic [DATA_W-1:0] r_p0_rd_data,   w_p0_rd_data_nxt;
    logic [DATA_W-1:0] r_p1_rd_data,   w_p1_rd_data_nxt;
    logic              r_p0_rd_ready,  w_p0_rd_ready_nxt;
    logic              r_p1_rd_ready,  w_p1_rd_ready_nxt;
    logic              r_p1_wr_ready,  w_p1_wr_ready_nxt;

    logic              w_p0_req;
    logic              w_p1_req;
    logic              w_pick;

    // The port just served still shows valid during its ready cycle, so it is
    // excluded for that one IDLE cycle.
    assign w_p0_req = p0_rd_valid && !(r_mask_vld && !r_mask_port);
    assign w_p1_req = (p1_rd_valid || p1_wr_valid) && !(r_mask_vld && r_mask_port);
    assign w_pick   = (w_p0_req && w_p1_req) ? ~r_last_grant : w_p1_req;

    always_comb begin
        w_state_nxt        = r_state;
        w_last_grant_nxt   = r_last_grant;
        w_mask_vld_nxt     = r_mask_vld;
        w_mask_port_nxt    = r_mask_port;
        w_gnt_port_nxt     = r_gnt_port;
        w_gnt_wr_nxt       = r_gnt_wr;
        w_mem_rd_addr_nxt  = r_mem_rd_addr;
        w_mem_wr_addr_nxt  = r_mem_wr_addr;
        w_mem_wr_data_nxt  = r_mem_wr_data;
        w_mem_rd_valid_nxt = r_mem_rd_valid;
        w_mem_wr_valid_nxt = r_mem_wr_valid;
        w_p0_rd_data_nxt   = r_p0_rd_data;
        w_p1_rd_data_nxt   = r_p1_rd_data;
        w_p0_rd_ready_nxt  = 1'b0;
        w_p1_rd_ready_nxt  = 1'b0;
        w_p1_wr_ready_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_mask_vld_nxt = 1'b0;
                if (w_p0_req || w_p1_req) begin
                    w_gnt_port_nxt   = w_pick;
                    w_gnt_wr_nxt     = w_pick && p1_wr_valid;
                    w_last_grant_nxt = w_pick;
                    w_state_nxt      = S_ISSUE;
                    if (w_pick && p1_wr_valid) begin
                        w_mem_wr_addr_nxt  = p1_wr_addr;
                        w_mem_wr_data_nxt  = p1_wr_data;
                        w_mem_wr_valid_nxt = 1'b1;
                    end else begin
                        w_mem_rd_addr_nxt  = w_pick ? p1_rd_addr : p0_rd_addr;
                        w_mem_rd_valid_nxt = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (r_gnt_wr && mem_wr_ready) begin
                    w_mem_wr_valid_nxt = 1'b0;
                    w_state_nxt        = S_RESP;
                end else if (!r_gnt_wr && mem_rd_ready) begin
                    w_mem_rd_valid_nxt = 1'b0;
                    w_state_nxt        = S_RESP;
                    if (r_gnt_port) begin
                        w_p1_rd_data_nxt = mem_rd_data;
                    end else begin
                        w_p0_rd_data_nxt = mem_rd_data;
                    end
                end
            end
            S_RESP: begin
                w_p0_rd_ready_nxt = !r_gnt_port;
                w_p1_rd_ready_nxt = r_gnt_port && !r_gnt_wr;
                w_p1_wr_ready_nxt = r_gnt_port && r_gnt_wr;
                w_mask_vld_nxt    = 1'b1;
                w_mask_port_nxt   = r_gnt_port;
                w_state_nxt       = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= S_IDLE;
            r_last_grant   <= 1'b1;
            r_mask_vld     <= 1'b0;
            r_mask_port    <= 1'b0;
            r_gnt_port     <= 1'b0;
            r_gnt_wr       <= 1'b0;
            r_mem_rd_addr  <= '0;
            r_mem_wr_addr  <= '0;
            r_mem_wr_data  <= '0;
            r_mem_rd_valid <= 1'b0;
            r_mem_wr_valid <= 1'b0;
            r_p0_rd_data   <= '0;
            r_p1_rd_data   <= '0;
            r_p0_rd_ready  <= 1'b0;
            r_p1_rd_ready  <= 1'b0;
            r_p1_wr_ready  <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_last_grant   <= w_last_grant_nxt;
            r_mask_vld     <= w_mask_vld_nxt;
            r_mask_port    <= w_mask_port_nxt;
            r_gnt_port     <= w_gnt_port_nxt;
            r_gnt_wr       <= w_gnt_wr_nxt;
            r_mem_rd_addr  <= w_mem_rd_addr_nxt;
            r_mem_wr_addr  <= w_mem_wr_addr_nxt;
            r_mem_wr_data  <= w_mem_wr_data_nxt;
            r_mem_rd_valid <= w_mem_rd_valid_nxt;
            r_mem_wr_valid <= w_mem_wr_valid_nxt;
            r_p0_rd_data   <= w_p0_rd_data_nxt;
            r_p1_rd_data   <= w_p1_rd_data_nxt;
            r_p0_rd_ready  <= w_p0_rd_ready_nxt;
            r_p1_rd_ready  <= w_p1_rd_ready_nxt;
            r_p1_wr_ready  <= w_p1_wr_ready_nxt;
        end
    end

    assign p0_rd_data   = r_p0_rd_data;
    assign p0_rd_ready  = r_p0_rd_ready;
    assign p1_rd_data   = r_p1_rd_data;
    assign p1_rd_ready  = r_p1_rd_ready;
    assign p1_wr_ready  = r_p1_wr_ready;
    assign mem_rd_addr  = r_mem_rd_addr;
    assign mem_rd_valid = r_mem_rd_valid;
    assign mem_wr_addr  = r_mem_wr_addr;
    assign mem_wr_data  = r_mem_wr_data;
    assign mem_wr_valid = r_mem_wr_valid;

endmodule

`default_nettype wire

// File: tb/tb_main_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_main_mem_arbiter
// Purpose  : Self-checking bench for main_mem_arbiter with a transaction-level
//            reference model, directed scenarios and randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_main_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [AW-1:0] p0_rd_addr = '0;
    logic          p0_rd_valid = 1'b0;
    logic [DW-1:0] p0_rd_data;
    logic          p0_rd_ready;
    logic [AW-1:0] p1_rd_addr = '0;
    logic          p1_rd_valid = 1'b0;
    logic [DW-1:0] p1_rd_data;
    logic          p1_rd_ready;
    logic [AW-1:0] p1_wr_addr = '0;
    logic [DW-1:0] p1_wr_data = '0;
    logic          p1_wr_valid = 1'b0;
    logic          p1_wr_ready;
    logic [AW-1:0] mem_rd_addr;
    logic          mem_rd_valid;
    logic [DW-1:0] mem_rd_data = '0;
    logic          mem_rd_ready = 1'b0;
    logic [AW-1:0] mem_wr_addr;
    logic [DW-1:0] mem_wr_data;
    logic          mem_wr_valid;
    logic          mem_wr_ready = 1'b0;

    main_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .p0_rd_addr(p0_rd_addr), .p0_rd_valid(p0_rd_valid),
        .p0_rd_data(p0_rd_data), .p0_rd_ready(p0_rd_ready),
        .p1_rd_addr(p1_rd_addr), .p1_rd_valid(p1_rd_valid),
        .p1_rd_data(p1_rd_data), .p1_rd_ready(p1_rd_ready),
        .p1_wr_addr(p1_wr_addr), .p1_wr_data(p1_wr_data),
        .p1_wr_valid(p1_wr_valid), .p1_wr_ready(p1_wr_ready),
        .mem_rd_addr(mem_rd_addr), .mem_rd_valid(mem_rd_valid),
        .mem_rd_data(mem_rd_data), .mem_rd_ready(mem_rd_ready),
        .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    // ---------------- reference model (one transaction in flight) ----------
    bit            m_busy, m_done, m_wr, m_port, m_last;
    int            m_mask;
    bit            e_rd_valid, e_wr_valid, e_p0_rdy, e_p1_rdy, e_p1w_rdy;
    logic [AW-1:0] e_rd_addr, e_wr_addr;
    logic [DW-1:0] e_wr_data, e_p0_data, e_p1_data;
    logic [AW-1:0] wlog_addr = '0;
    logic [DW-1:0] wlog_data = '0;

    task automatic model_reset();
        m_busy = 0; m_done = 0; m_wr = 0; m_port = 0; m_last = 1; m_mask = -1;
        e_rd_valid = 0; e_wr_valid = 0; e_p0_rdy = 0; e_p1_rdy = 0; e_p1w_rdy = 0;
        e_rd_addr = '0; e_wr_addr = '0; e_wr_data = '0; e_p0_data = '0; e_p1_data = '0;
    endtask

    task automatic model_step();
        bit r0, r1;
        e_p0_rdy = 0; e_p1_rdy = 0; e_p1w_rdy = 0;
        if (!m_busy) begin
            r0 = p0_rd_valid && (m_mask != 0);
            r1 = (p1_rd_valid || p1_wr_valid) && (m_mask != 1);
            m_mask = -1;
            if (r0 || r1) begin
                m_port = (r0 && r1) ? !m_last : r1;
                m_last = m_port;
                m_busy = 1;
                m_done = 0;
                m_wr   = m_port && p1_wr_valid;
                if (m_wr) begin
                    e_wr_valid = 1; e_wr_addr = p1_wr_addr; e_wr_data = p1_wr_data;
                end else begin
                    e_rd_valid = 1; e_rd_addr = m_port ? p1_rd_addr : p0_rd_addr;
                end
            end
        end else if (!m_done) begin
            if (m_wr ? mem_wr_ready : mem_rd_ready) begin
                m_done = 1; e_rd_valid = 0; e_wr_valid = 0;
                if (!m_wr && m_port) e_p1_data = mem_rd_data;
                if (!m_wr && !m_port) e_p0_data = mem_rd_data;
            end
        end else begin
            m_busy = 0;
            m_mask = m_port;
            if (m_wr) e_p1w_rdy = 1;
            else if (m_port) e_p1_rdy = 1;
            else e_p0_rdy = 1;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                model_reset();
            end else begin
                if (mem_wr_valid && mem_wr_ready) begin
                    wlog_addr = mem_wr_addr;
                    wlog_data = mem_wr_data;
                end
                model_step();
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("cycle_outputs",
                {mem_rd_valid, mem_wr_valid, p0_rd_ready, p1_rd_ready, p1_wr_ready,
                 mem_rd_addr, mem_wr_addr, mem_wr_data, p0_rd_data, p1_rd_data},
                {e_rd_valid, e_wr_valid, e_p0_rdy, e_p1_rdy, e_p1w_rdy,
                 e_rd_addr, e_wr_addr, e_wr_data, e_p0_data, e_p1_data});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ---------------------------------------------
    int mem_mode = 0;   // 0 manual, 1 always ready, 2 random
    bit p0_act = 0, p1r_act = 0, p1w_act = 0;
    int done_cnt = 0;

    task automatic cyc();
        @(negedge clk);
        if (mem_mode == 1) begin
            mem_rd_ready = 1; mem_wr_ready = 1; mem_rd_data = mem_word(mem_rd_addr);
        end else if (mem_mode == 2) begin
            mem_rd_ready = ($urandom_range(0, 3) == 0);
            mem_wr_ready = ($urandom_range(0, 3) == 0);
            mem_rd_data  = mem_rd_valid ? mem_word(mem_rd_addr) : $urandom;
        end
    endtask

    task automatic rand_req(input bit allow);
        if (p0_act && p0_rd_ready) begin
            chk("rnd_p0_data", p0_rd_data, mem_word(p0_rd_addr));
            p0_act = 0; done_cnt++;
        end else if (!p0_act) begin
            if (allow && $urandom_range(0, 2) == 0) begin
                p0_rd_addr = 32'($urandom_range(0, 255)) << 2; p0_rd_valid = 1; p0_act = 1;
            end else p0_rd_valid = 0;
        end
        if (p1r_act && p1_rd_ready) begin
            chk("rnd_p1_data", p1_rd_data, mem_word(p1_rd_addr));
            p1r_act = 0; done_cnt++;
        end else if (!p1r_act) begin
            if (allow && $urandom_range(0, 3) == 0) begin
                p1_rd_addr = 32'($urandom_range(256, 511)) << 2; p1_rd_valid = 1; p1r_act = 1;
            end else p1_rd_valid = 0;
        end
        if (p1w_act && p1_wr_ready) begin
            chk("rnd_p1_wr", {wlog_addr, wlog_data}, {p1_wr_addr, p1_wr_data});
            p1w_act = 0; done_cnt++;
        end else if (!p1w_act) begin
            if (allow && $urandom_range(0, 3) == 0) begin
                p1_wr_addr = 32'($urandom_range(0, 1023)) << 2; p1_wr_data = $urandom;
                p1_wr_valid = 1; p1w_act = 1;
            end else p1_wr_valid = 0;
        end
    endtask

    initial begin
        int n, n0, n1;
        logic [5:0] gseq;

        repeat (3) cyc();
        chk("reset_state",
            {mem_rd_valid, mem_wr_valid, p0_rd_ready, p1_rd_ready, p1_wr_ready,
             mem_rd_addr, mem_wr_addr, mem_wr_data, p0_rd_data, p1_rd_data}, '0);
        reset = 1;

        // single fetch with a 2-cycle memory stall
        cyc(); p0_rd_addr = 32'h100; p0_rd_valid = 1;
        cyc(); chk("fetch_issue", {mem_rd_valid, mem_rd_addr}, {1'b1, 32'h100});
        cyc(); cyc(); mem_rd_data = 32'hDEAD_BEEF; mem_rd_ready = 1;
        cyc(); mem_rd_ready = 0; mem_rd_data = '0;
        chk("fetch_no_early_ready", p0_rd_ready, 1'b0);
        cyc(); chk("fetch_ready", {p0_rd_ready, p1_rd_ready, p1_wr_ready}, 3'b100);
        chk("fetch_data", p0_rd_data, 32'hDEAD_BEEF);

        // exec store with immediate memory ready
        cyc(); p0_rd_valid = 0;
        p1_wr_addr = 32'h40; p1_wr_data = 32'h1234_5678; p1_wr_valid = 1;
        cyc(); chk("store_issue", {mem_wr_valid, mem_rd_valid, mem_wr_addr, mem_wr_data},
                   {1'b1, 1'b0, 32'h40, 32'h1234_5678});
        mem_wr_ready = 1;
        cyc(); mem_wr_ready = 0;
        cyc(); chk("store_ready", {p0_rd_ready, p1_rd_ready, p1_wr_ready}, 3'b001);
        cyc(); p1_wr_valid = 0;

        // contention straight out of reset: p0 first, p1 right after p0's ready
        reset = 0; cyc(); reset = 1;
        mem_mode = 1;
        cyc(); p0_rd_addr = 32'h0; p1_rd_addr = 32'h4; p0_rd_valid = 1; p1_rd_valid = 1;
        cyc(); chk("cont_p0_issue", {mem_rd_valid, mem_rd_addr}, {1'b1, 32'h0});
        cyc();
        cyc(); chk("cont_p0_ready", {p0_rd_ready, p1_rd_ready, p0_rd_data}, {2'b10, mem_word(32'h0)});
        cyc(); p0_rd_valid = 0;
        chk("cont_p1_issue", {mem_rd_valid, mem_rd_addr}, {1'b1, 32'h4});
        cyc();
        cyc(); chk("cont_p1_ready", {p0_rd_ready, p1_rd_ready, p1_rd_data}, {2'b01, mem_word(32'h4)});
        cyc(); p1_rd_valid = 0;

        // fairness under continuous requests
        cyc(); cyc();
        p0_rd_addr = 32'h10; p1_rd_addr = 32'h14; p0_rd_valid = 1; p1_rd_valid = 1;
        n = 0; n0 = 0; n1 = 0; gseq = '0;
        for (int c = 0; c < 100 && n < 6; c++) begin
            cyc();
            if (p0_rd_ready) begin
                gseq[n] = 1'b0; n++; n0++;
                if (n0 == 3) p0_rd_valid = 0;
            end
            if (p1_rd_ready) begin
                gseq[n] = 1'b1; n++; n1++;
                if (n1 == 3) p1_rd_valid = 0;
            end
        end
        chk("fair_count", n, 6);
        chk("fair_order", gseq, 6'b101010);
        p0_rd_valid = 0; p1_rd_valid = 0;

        // stray and inactive-channel readies
        mem_mode = 0;
        cyc(); mem_rd_ready = 0; mem_wr_ready = 0;
        cyc(); mem_rd_ready = 1; mem_rd_data = 32'h55;
        cyc(); mem_rd_ready = 0;
        chk("stray_idle_quiet", {mem_rd_valid, mem_wr_valid, p0_rd_ready, p1_rd_ready, p1_wr_ready}, 5'b0);
        chk("stray_p0_hold", p0_rd_data, mem_word(32'h10));
        p0_rd_addr = 32'h200; p0_rd_valid = 1;
        cyc(); mem_wr_ready = 1;
        cyc(); cyc(); mem_wr_ready = 0;
        chk("stray_wr_ignored", {mem_rd_valid, p0_rd_ready, p1_wr_ready}, 3'b100);
        mem_rd_ready = 1; mem_rd_data = 32'hCAFE_F00D;
        cyc(); mem_rd_ready = 0;
        cyc(); chk("stray_read_done", {p0_rd_ready, p0_rd_data}, {1'b1, 32'hCAFE_F00D});
        cyc(); p0_rd_valid = 0;

        // reset in the middle of an issued read
        cyc(); p0_rd_addr = 32'h300; p0_rd_valid = 1;
        cyc(); cyc(); chk("midop_issue", mem_rd_valid, 1'b1);
        #2 reset = 0;
        #1 chk("midop_reset_now",
               {mem_rd_valid, mem_wr_valid, p0_rd_ready, p1_rd_ready, p1_wr_ready, mem_rd_addr}, '0);
        cyc(); reset = 1; mem_mode = 1;
        p1_rd_addr = 32'h500; p1_rd_valid = 1;
        cyc(); chk("midop_p0_first", {mem_rd_valid, mem_rd_addr}, {1'b1, 32'h300});
        cyc();
        cyc(); chk("midop_p0_ready", {p0_rd_ready, p0_rd_data}, {1'b1, mem_word(32'h300)});
        cyc(); p0_rd_valid = 0;
        cyc();
        cyc(); chk("midop_p1_ready", {p1_rd_ready, p1_rd_data}, {1'b1, mem_word(32'h500)});
        cyc(); p1_rd_valid = 0;

        // randomized traffic with random stalls and stray readies
        mem_mode = 2;
        for (int c = 0; c < 3000; c++) begin
            cyc(); rand_req(1);
        end
        for (int c = 0; c < 1000 && (p0_act || p1r_act || p1w_act); c++) begin
            cyc(); rand_req(0);
        end
        chk("drain_complete", {p0_act, p1r_act, p1w_act}, 3'b0);
        chk("rnd_progress", (done_cnt > 100), 1'b1);
        repeat (3) begin
            cyc(); rand_req(0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
